// File: rtl/msg_out_pkg.sv
// Shared definitions for the character output port: register map,
// STATUS/CTRL bit positions and the register-select decode.
package msg_out_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef enum logic [1:0] {SEL_NONE, SEL_DATA, SEL_STATUS, SEL_CTRL} reg_sel_e;

  // Map the low nibble of a byte address to a register; 0xC and
  // unaligned offsets select nothing.
  function automatic reg_sel_e decode_off(logic [3:0] off);
    case (off)
      OFF_DATA:   return SEL_DATA;
      OFF_STATUS: return SEL_STATUS;
      OFF_CTRL:   return SEL_CTRL;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/msg_out_port_if.sv
// CPU bus + character stream bundle for msg_out_port.
// master = CPU/consumer side, slave = the peripheral.
interface msg_out_port_if #(
  parameter int ADDR_W = 11,
  parameter int CHAR_W = 8
);
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       write_data;
  logic              hit;
  logic [31:0]       read_data;
  logic [CHAR_W-1:0] out_char;
  logic              out_valid;
  logic              out_ready;
  logic              irq;

  modport master (
    output mem_write, addr, write_data, out_ready,
    input  hit, read_data, out_char, out_valid, irq
  );

  modport slave (
    input  mem_write, addr, write_data, out_ready,
    output hit, read_data, out_char, out_valid, irq
  );
endinterface

// File: rtl/msg_fifo.sv
// Generic first-word-fall-through FIFO. Pointers carry an extra wrap bit
// so full/empty come from pointer compares; occupancy is its own counter.
// Storage is deliberately not reset.
module msg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         push_ok, pop_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A push into a full FIFO is only taken when the head leaves the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr[AW-1:0]];

  // Entry storage, written on accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

  // Pointers and count; flush beats any same-edge pop or push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/msg_out_port.sv
// Memory-mapped character output port: DATA/STATUS/CTRL window at BASE,
// buffered into msg_fifo and drained over valid/ready.
// Build option: MSG_OUT_NUL_FILTER_EN drops DATA writes of a zero char.
module msg_out_port
  import msg_out_pkg::*;
#(
  parameter int              ADDR_W = 11,
  parameter logic [ADDR_W-1:0] BASE = 11'h400,
  parameter int              CHAR_W = 8,
  parameter int              DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  msg_out_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  reg_sel_e          sel;
  logic              wr_data, wr_ctrl, push, pop, flush, clr_ovf;
  logic              full, empty, overflow;
  logic [AW:0]       count;
  logic [CHAR_W-1:0] wchar;
  logic [31:0]       status;
  logic              unused_wd;

  // Window decode is purely combinational on the address.
  assign sel     = (bus.addr[ADDR_W-1:4] == BASE[ADDR_W-1:4]) ? decode_off(bus.addr[3:0])
                                                               : SEL_NONE;
  assign bus.hit = (sel != SEL_NONE);

  assign wchar   = bus.write_data[CHAR_W-1:0];
  assign wr_data = bus.mem_write && (sel == SEL_DATA);
  assign wr_ctrl = bus.mem_write && (sel == SEL_CTRL);
  assign flush   = wr_ctrl && bus.write_data[CTRL_FLUSH];
  assign clr_ovf = wr_ctrl && bus.write_data[CTRL_CLR_OVF];
  assign pop     = bus.out_valid && bus.out_ready;

`ifdef MSG_OUT_NUL_FILTER_EN
  // NUL chars vanish before reaching the FIFO or the overflow logic.
  assign push = wr_data && (wchar != '0);
`else
  assign push = wr_data;
`endif

  assign unused_wd = ^bus.write_data[31:CHAR_W];

  msg_fifo #(.W(CHAR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wchar),
    .pop   (pop),
    .flush (flush),
    .dout  (bus.out_char),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow: a push lost because the FIFO was full with no pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          overflow <= 1'b0;
    else if (clr_ovf)                  overflow <= 1'b0;
    else if (push && full && !pop)     overflow <= 1'b1;
  end

  // STATUS word assembly.
  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = empty;
    status[ST_FULL]             = full;
    status[ST_OVF]              = overflow;
    status[ST_CNT_LSB +: AW+1]  = count;
  end

  assign bus.read_data = (sel == SEL_STATUS) ? status : 32'h0;
  assign bus.out_valid = !empty;
  assign bus.irq       = (count >= (AW+1)'(DEPTH/2)) || overflow;

endmodule

// File: tb/tb_msg_out_port.sv
// Bench for msg_out_port: decode table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_msg_out_port;

  localparam int          ADDR_W = 11;
  localparam logic [10:0] BASE   = 11'h400;
  localparam int          DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msg_out_port_if #(.ADDR_W(ADDR_W), .CHAR_W(8)) bus ();

  msg_out_port #(.ADDR_W(ADDR_W), .BASE(BASE), .CHAR_W(8), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [7:0] q[$];
  bit         ovf;

  logic        we, rdy;
  logic [10:0] a;
  logic [31:0] wd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(logic [10:0] ad);
    return (ad >= BASE) && (ad <= BASE + 11'd11) && (ad % 4 == 0);
  endfunction

  // Drive one cycle's inputs after the falling edge and compare the
  // combinational outputs against the model's current state.
  task automatic drive(logic w, logic [10:0] ad, logic [31:0] d, logic r);
    logic [31:0] exp_rd;
    bit h;
    @(negedge clk);
    we = w; a = ad; wd = d; rdy = r;
    bus.mem_write = w; bus.addr = ad; bus.write_data = d; bus.out_ready = r;
    #1;
    h = m_hit(ad);
    exp_rd = 32'h0;
    if (h && (ad - BASE) == 11'd4)
      exp_rd = {16'h0, 8'(q.size()), 5'b0, ovf, q.size() == DEPTH, q.size() == 0};
    chk("hit", {31'b0, bus.hit}, {31'b0, h});
    chk("read_data", bus.read_data, exp_rd);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("out_char", {24'b0, bus.out_char}, {24'b0, q[0]});
    chk("irq", {31'b0, bus.irq}, {31'b0, (q.size() >= DEPTH/2) || ovf});
  endtask

  // Advance the model across the rising edge using the driven inputs.
  task automatic step();
    bit p, full_b, is_data, is_ctrl, nul;
    logic [7:0] tmp;
    @(posedge clk);
    full_b  = (q.size() == DEPTH);
    p       = (q.size() != 0) && rdy;
    is_data = we && m_hit(a) && (a == BASE);
    is_ctrl = we && m_hit(a) && (a == BASE + 11'd8);
`ifdef MSG_OUT_NUL_FILTER_EN
    nul = (wd[7:0] == 8'h00);
`else
    nul = 1'b0;
`endif
    if (is_ctrl) begin
      if (wd[0]) q.delete();
      else if (p) tmp = q.pop_front();
      if (wd[1]) ovf = 1'b0;
    end else begin
      if (p) tmp = q.pop_front();
      if (is_data && !nul) begin
        if (full_b && !p) ovf = 1'b1;
        else q.push_back(wd[7:0]);
      end
    end
  endtask

  task automatic cycle(logic w, logic [10:0] ad, logic [31:0] d, logic r);
    drive(w, ad, d, r);
    step();
  endtask

  task automatic clear_all();
    cycle(1'b1, BASE + 11'd8, 32'h3, 1'b0);
  endtask

  typedef struct {
    logic [10:0] addr;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [7:0] last;
    int r;

    vt[0]  = '{11'h400, 1'b1, 32'h0};
    vt[1]  = '{11'h404, 1'b1, 32'h1};
    vt[2]  = '{11'h408, 1'b1, 32'h0};
    vt[3]  = '{11'h40C, 1'b0, 32'h0};
    vt[4]  = '{11'h401, 1'b0, 32'h0};
    vt[5]  = '{11'h402, 1'b0, 32'h0};
    vt[6]  = '{11'h405, 1'b0, 32'h0};
    vt[7]  = '{11'h3FC, 1'b0, 32'h0};
    vt[8]  = '{11'h410, 1'b0, 32'h0};
    vt[9]  = '{11'h000, 1'b0, 32'h0};
    vt[10] = '{11'h7FC, 1'b0, 32'h0};
    vt[11] = '{11'h40B, 1'b0, 32'h0};

    we = 0; a = 0; wd = 0; rdy = 0;
    bus.mem_write = 0; bus.addr = '0; bus.write_data = '0; bus.out_ready = 0;
    q.delete(); ovf = 0;
    #2;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // decode table, empty FIFO, reads only
    foreach (vt[i]) begin
      drive(1'b0, vt[i].addr, 32'h0, 1'b0);
      chk("vec_hit", {31'b0, bus.hit}, {31'b0, vt[i].exp_hit});
      chk("vec_rd", bus.read_data, vt[i].exp_rd);
      step();
    end

    // 1: "Hi" queued
    cycle(1'b1, BASE, 32'h48, 1'b0);
    cycle(1'b1, BASE, 32'h69, 1'b0);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t1_status", bus.read_data, 32'h0000_0200);
    chk("t1_char", {24'b0, bus.out_char}, 32'h48);
    step();
    clear_all();

    // 2: overflow on 17th push, drained order intact
    for (int i = 0; i < 17; i++) cycle(1'b1, BASE, 32'(8'h61 + i), 1'b0);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t2_status", bus.read_data, 32'h0000_1006);
    chk("t2_irq", {31'b0, bus.irq}, 32'h1);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 11'h0, 32'h0, 1'b1);
      chk("t2_drain", {24'b0, bus.out_char}, 32'(8'h61 + i));
      step();
    end
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t2_empty_ovf", bus.read_data, 32'h0000_0005);
    step();
    clear_all();

    // 3: full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cycle(1'b1, BASE, 32'(8'h61 + i), 1'b0);
    cycle(1'b1, BASE, 32'h5A, 1'b1);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t3_status", bus.read_data, 32'h0000_1002);
    step();
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 11'h0, 32'h0, 1'b1);
      last = bus.out_char;
      step();
    end
    chk("t3_last", {24'b0, last}, 32'h5A);
    clear_all();

    // 4: empty push with ready, no same-edge pop
    drive(1'b1, BASE, 32'h41, 1'b1);
    chk("t4_pre_valid", {31'b0, bus.out_valid}, 32'h0);
    step();
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b1);
    chk("t4_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("t4_char", {24'b0, bus.out_char}, 32'h41);
    step();
    clear_all();

    // 5: flush then clear overflow, irq drops
    for (int i = 0; i < 8; i++) cycle(1'b1, BASE, 32'(8'h30 + i), 1'b0);
    drive(1'b1, BASE + 11'd8, 32'h1, 1'b0);
    chk("t5_irq_hi", {31'b0, bus.irq}, 32'h1);
    step();
    cycle(1'b1, BASE + 11'd8, 32'h2, 1'b0);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t5_status", bus.read_data, 32'h0000_0001);
    chk("t5_irq_lo", {31'b0, bus.irq}, 32'h0);
    step();

    // 6: NUL handling
    cycle(1'b1, BASE, 32'h00, 1'b0);
    cycle(1'b1, BASE, 32'h42, 1'b0);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
`ifdef MSG_OUT_NUL_FILTER_EN
    chk("t6_status", bus.read_data, 32'h0000_0100);
    chk("t6_head", {24'b0, bus.out_char}, 32'h42);
`else
    chk("t6_status", bus.read_data, 32'h0000_0200);
    chk("t6_head", {24'b0, bus.out_char}, 32'h00);
`endif
    step();
    clear_all();

    // 7: async reset mid-drain
    for (int i = 0; i < 5; i++) cycle(1'b1, BASE, 32'(8'h50 + i), 1'b0);
    cycle(1'b0, 11'h0, 32'h0, 1'b1);
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b1);
    chk("t7_pre_valid", {31'b0, bus.out_valid}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t7_valid_async", {31'b0, bus.out_valid}, 32'h0);
    chk("t7_irq_async", {31'b0, bus.irq}, 32'h0);
    q.delete(); ovf = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    drive(1'b0, BASE + 11'd4, 32'h0, 1'b0);
    chk("t7_status", bus.read_data, 32'h0000_0001);
    chk("t7_hit", {31'b0, bus.hit}, 32'h1);
    step();

    // randomized traffic vs model
    for (int i = 0; i < 800; i++) begin
      logic [10:0] ra;
      logic [31:0] rd;
      logic rw, rr;
      r  = $urandom_range(0, 15);
      rd = $urandom();
      if ($urandom_range(0, 7) == 0) rd[7:0] = 8'h00;
      if (r <= 6)       ra = BASE;
      else if (r <= 9)  ra = BASE + 11'd4;
      else if (r == 10) ra = BASE + 11'd8;
      else if (r == 11) ra = BASE + 11'd12;
      else              ra = 11'($urandom());
      rw = ($urandom_range(0, 3) != 0);
      if (i < 400) rr = ($urandom_range(0, 3) == 0);
      else         rr = ($urandom_range(0, 3) != 0);
      cycle(rw, ra, rd, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
